// File: rtl/inst_fetch_unit_if.sv
// Instruction-bus handshake between the fetch stage and the bus.
// One-cycle ack qualifies rdata; req holds with a stable addr until ack.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the bus handshake and
// presents {pc, inst, valid} to IF/ID under control-unit stall/flush.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    inst_fetch_unit_if.master bus,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o,
    output logic              if_valid_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DISCARD
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] buf_q;
    logic [ADDR_W-1:0] pc_d;
    logic              pc_hold;
    logic              unused_stall;

    assign pc_hold      = stall_i[0];
    assign unused_stall = ^stall_i[5:1];

    assign pc_d = branch_flag_i ? branch_target_i
                                : pc_q + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
            pc_q    <= ADDR_W'(RESET_PC);
            addr_q  <= ADDR_W'(RESET_PC);
            buf_q   <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    addr_q <= pc_q;
                    if (flush_i) begin
                        pc_q    <= new_pc_i;
                        state_q <= bus.ack ? FETCH : DISCARD;
                    end else if (bus.ack) begin
                        if (pc_hold) begin
                            buf_q   <= bus.rdata;
                            state_q <= HOLD;
                        end else begin
                            pc_q <= pc_d;
                        end
                    end
                end
                HOLD: begin
                    if (flush_i) begin
                        pc_q    <= new_pc_i;
                        state_q <= FETCH;
                    end else if (!pc_hold) begin
                        pc_q    <= pc_d;
                        state_q <= FETCH;
                    end
                end
                DISCARD: begin
                    if (flush_i) begin
                        pc_q <= new_pc_i;
                    end
                    // The orphaned request is over once acked, even under a
                    // fresh flush: pc already holds the newest target.
                    if (bus.ack) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.req    = 1'b0;
        bus.addr   = '0;
        if_pc_o    = '0;
        if_inst_o  = '0;
        if_valid_o = 1'b0;
        stallreq_o = 1'b0;
        if (rst) begin
            if_pc_o = pc_q;
            unique case (state_q)
                FETCH: begin
                    bus.req    = 1'b1;
                    bus.addr   = pc_q;
                    if_inst_o  = bus.rdata;
                    if_valid_o = bus.ack & ~flush_i;
                    stallreq_o = ~bus.ack;
                end
                HOLD: begin
                    bus.addr   = pc_q;
                    if_inst_o  = buf_q;
                    if_valid_o = ~flush_i;
                end
                DISCARD: begin
                    bus.req    = 1'b1;
                    bus.addr   = addr_q;
                    stallreq_o = 1'b1;
                end
                default: begin
                    bus.req = 1'b0;
                end
            endcase
        end
    end

endmodule
